// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the output-stationary systolic array: default
// operand/result widths, the PE state encoding, and the arithmetic helpers
// (saturating add, round-half-up shift with saturation) used by the PE and
// by the array wrapper.
//
// The helpers operate on a fixed FN_W-bit signed working word. Callers
// sign-extend their operands into it and truncate the result back to their
// own width; every width passed in must be no greater than FN_W-2 so that
// the intermediate sums cannot overflow the working word.
// -----------------------------------------------------------------------------
package systolic_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 16;
    localparam int unsigned DEF_WEIGHT_WIDTH = 8;
    localparam int unsigned DEF_ACCUM_WIDTH  = 32;
    localparam int unsigned DEF_OUT_WIDTH    = 16;
    localparam int unsigned DEF_OUT_SHIFT    = 6;
    localparam bit          DEF_SATURATE     = 1'b1;

    // Working width of the arithmetic helpers.
    localparam int unsigned FN_W = 64;

    typedef logic signed [FN_W-1:0] fn_word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } pe_state_e;

    // Bring a working-word value into the signed range of 'width' bits,
    // either by clamping or by two's-complement wrap (re-sign-extending the
    // low 'width' bits).
    function automatic fn_word_t fit_width(
        input fn_word_t    value,
        input int unsigned width,
        input bit          saturate
    );
        fn_word_t max_v;
        fn_word_t min_v;
        fn_word_t res;
        max_v = (fn_word_t'(1) <<< (width - 1)) - fn_word_t'(1);
        min_v = -max_v - fn_word_t'(1);
        if (saturate) begin
            if (value > max_v) begin
                res = max_v;
            end else if (value < min_v) begin
                res = min_v;
            end else begin
                res = value;
            end
        end else begin
            res = (value <<< (FN_W - width)) >>> (FN_W - width);
        end
        return res;
    endfunction

    // a + b limited to a signed 'width'-bit range.
    function automatic fn_word_t sat_add(
        input fn_word_t    a,
        input fn_word_t    b,
        input int unsigned width,
        input bit          saturate
    );
        return fit_width(a + b, width, saturate);
    endfunction

    // round_half_up(value >>> shift), limited to a signed 'out_width' range.
    // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
    function automatic fn_word_t round_shift_sat(
        input fn_word_t    value,
        input int unsigned shift,
        input int unsigned out_width,
        input bit          saturate
    );
        fn_word_t half;
        half = (shift == 0) ? '0 : (fn_word_t'(1) <<< (shift - 1));
        return fit_width((value + half) >>> shift, out_width, saturate);
    endfunction

endpackage

// File: rtl/systolic_pe_os_if.sv
// -----------------------------------------------------------------------------
// systolic_pe_os_if
// Boundary signals of one output-stationary PE, grouped as one bundle.
//   Left  -> right : data_*_in_L  / data_*_out_R   (activation + tile markers)
//   Top   -> bottom: weight_*_in_T / weight_*_out_B (weights)
//   Drain column   : drain_shift, result_*_in_T / result_*_out_B
//   Status         : busy, err_mismatch, err_overrun
// modport slave  : the PE's view (consumes *_in_*, produces *_out_* + status)
// modport master : the driver's view (the opposite directions)
// -----------------------------------------------------------------------------
interface systolic_pe_os_if #(
    parameter int unsigned DATA_WIDTH   = systolic_pkg::DEF_DATA_WIDTH,
    parameter int unsigned WEIGHT_WIDTH = systolic_pkg::DEF_WEIGHT_WIDTH,
    parameter int unsigned OUT_WIDTH    = systolic_pkg::DEF_OUT_WIDTH
);

    logic [DATA_WIDTH-1:0]   data_in_L;
    logic                    data_valid_in_L;
    logic                    data_first_in_L;
    logic                    data_last_in_L;
    logic [DATA_WIDTH-1:0]   data_out_R;
    logic                    data_valid_out_R;
    logic                    data_first_out_R;
    logic                    data_last_out_R;

    logic [WEIGHT_WIDTH-1:0] weight_in_T;
    logic                    weight_valid_in_T;
    logic [WEIGHT_WIDTH-1:0] weight_out_B;
    logic                    weight_valid_out_B;

    logic                    drain_shift;
    logic [OUT_WIDTH-1:0]    result_in_T;
    logic                    result_valid_in_T;
    logic [OUT_WIDTH-1:0]    result_out_B;
    logic                    result_valid_out_B;

    logic                    busy;
    logic                    err_mismatch;
    logic                    err_overrun;

    modport slave (
        input  data_in_L, data_valid_in_L, data_first_in_L, data_last_in_L,
        output data_out_R, data_valid_out_R, data_first_out_R, data_last_out_R,
        input  weight_in_T, weight_valid_in_T,
        output weight_out_B, weight_valid_out_B,
        input  drain_shift, result_in_T, result_valid_in_T,
        output result_out_B, result_valid_out_B,
        output busy, err_mismatch, err_overrun
    );

    modport master (
        output data_in_L, data_valid_in_L, data_first_in_L, data_last_in_L,
        input  data_out_R, data_valid_out_R, data_first_out_R, data_last_out_R,
        output weight_in_T, weight_valid_in_T,
        input  weight_out_B, weight_valid_out_B,
        output drain_shift, result_in_T, result_valid_in_T,
        input  result_out_B, result_valid_out_B,
        input  busy, err_mismatch, err_overrun
    );

endinterface

// File: rtl/pe_result_stage.sv
// -----------------------------------------------------------------------------
// pe_result_stage
// Result side of a PE: rounds and limits the final accumulator, holds it in
// the result register, and forms one slot of the per-column drain chain.
//   clk, rst          : clock, asynchronous active-high reset
//   en                : global advance; 0 holds the register and flag
//   load              : final accumulator is valid this cycle (already gated by en)
//   acc_final         : accumulator value including the last product
//   drain_shift       : column drain strobe
//   result_in         : result_valid_in  : slot from the PE above
//   result_out        : result_valid_out : slot to the PE below
//   err_overrun       : sticky, a valid result was dropped
// A local load has priority over a shift; the value it displaces (held here
// or arriving from above) is what gets lost and flagged.
// -----------------------------------------------------------------------------
module pe_result_stage #(
    parameter int unsigned ACCUM_WIDTH = systolic_pkg::DEF_ACCUM_WIDTH,
    parameter int unsigned OUT_WIDTH   = systolic_pkg::DEF_OUT_WIDTH,
    parameter int unsigned OUT_SHIFT   = systolic_pkg::DEF_OUT_SHIFT,
    parameter bit          SATURATE    = systolic_pkg::DEF_SATURATE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          load,
    input  logic signed [ACCUM_WIDTH-1:0] acc_final,
    input  logic                          drain_shift,
    input  logic [OUT_WIDTH-1:0]          result_in,
    input  logic                          result_valid_in,
    output logic [OUT_WIDTH-1:0]          result_out,
    output logic                          result_valid_out,
    output logic                          err_overrun
);
    import systolic_pkg::*;

    logic [OUT_WIDTH-1:0] rounded;
    logic                 overrun_hit;

    always_comb begin
        rounded = OUT_WIDTH'(round_shift_sat(fn_word_t'(acc_final), OUT_SHIFT,
                                             OUT_WIDTH, SATURATE));
    end

    // Without a shift the held value is overwritten; with a shift the held
    // value moves down safely but the valid one arriving from above is lost.
    assign overrun_hit = load & ((result_valid_out & ~drain_shift) |
                                 (drain_shift & result_valid_in));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_out       <= '0;
            result_valid_out <= 1'b0;
            err_overrun      <= 1'b0;
        end else if (en) begin
            if (load) begin
                result_out       <= rounded;
                result_valid_out <= 1'b1;
            end else if (drain_shift) begin
                result_out       <= result_in;
                result_valid_out <= result_valid_in;
            end
            if (overrun_hit) begin
                err_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/systolic_pe_os.sv
// -----------------------------------------------------------------------------
// systolic_pe_os
// Output-stationary systolic processing element. Activations and tile
// markers move one register stage to the right, weights one stage down.
// Each firing pair (both valids high while en) adds its signed product to
// the accumulator; the pair marked last hands the final sum to the result
// stage, which rounds, limits and drains it down the column. A new tile may
// accumulate while the previous result is still draining.
//   clk, rst : clock, asynchronous active-high reset
//   en       : global advance; 0 freezes every register
//   pe       : systolic_pe_os_if.slave bundle (pass-through, drain, status)
// -----------------------------------------------------------------------------
module systolic_pe_os #(
    parameter int unsigned DATA_WIDTH   = systolic_pkg::DEF_DATA_WIDTH,
    parameter int unsigned WEIGHT_WIDTH = systolic_pkg::DEF_WEIGHT_WIDTH,
    parameter int unsigned ACCUM_WIDTH  = systolic_pkg::DEF_ACCUM_WIDTH,
    parameter int unsigned OUT_WIDTH    = systolic_pkg::DEF_OUT_WIDTH,
    parameter int unsigned OUT_SHIFT    = systolic_pkg::DEF_OUT_SHIFT,
    parameter bit          SATURATE     = systolic_pkg::DEF_SATURATE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    systolic_pe_os_if.slave pe
);
    import systolic_pkg::*;

    localparam int unsigned PROD_W = DATA_WIDTH + WEIGHT_WIDTH;

    pe_state_e state;
    pe_state_e state_next;

    logic                          fire;
    logic                          mismatch;
    logic                          eff_first;
    logic                          load;
    logic signed [PROD_W-1:0]      data_ext;
    logic signed [PROD_W-1:0]      weight_ext;
    logic signed [PROD_W-1:0]      product;
    logic signed [ACCUM_WIDTH-1:0] acc;
    logic signed [ACCUM_WIDTH-1:0] acc_next;

    logic [DATA_WIDTH-1:0]   data_r;
    logic                    data_valid_r;
    logic                    data_first_r;
    logic                    data_last_r;
    logic [WEIGHT_WIDTH-1:0] weight_r;
    logic                    weight_valid_r;
    logic                    err_mismatch_r;

    assign fire     = en & pe.data_valid_in_L & pe.weight_valid_in_T;
    assign mismatch = en & (pe.data_valid_in_L ^ pe.weight_valid_in_T);

    // Both operands are sign-extended to the full product width first so the
    // multiply is exact in PROD_W bits.
    always_comb begin
        data_ext   = PROD_W'($signed(pe.data_in_L));
        weight_ext = PROD_W'($signed(pe.weight_in_T));
        product    = data_ext * weight_ext;
    end

    // ---------------- pass-through registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r         <= '0;
            data_valid_r   <= 1'b0;
            data_first_r   <= 1'b0;
            data_last_r    <= 1'b0;
            weight_r       <= '0;
            weight_valid_r <= 1'b0;
        end else if (en) begin
            data_r         <= pe.data_in_L;
            data_valid_r   <= pe.data_valid_in_L;
            data_first_r   <= pe.data_first_in_L;
            data_last_r    <= pe.data_last_in_L;
            weight_r       <= pe.weight_in_T;
            weight_valid_r <= pe.weight_valid_in_T;
        end
    end

    // ---------------- FSM / accumulator state ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            acc            <= '0;
            err_mismatch_r <= 1'b0;
        end else begin
            state <= state_next;
            if (fire) begin
                acc <= acc_next;
            end
            if (mismatch) begin
                err_mismatch_r <= 1'b1;
            end
        end
    end

    // A pair arriving in IDLE always starts a fresh sum, whether or not it
    // carries first; first inside ACC restarts the sum. Only fire moves the
    // state, so en=0 holds it implicitly.
    always_comb begin
        state_next = state;
        eff_first  = pe.data_first_in_L | (state == ST_IDLE);
        acc_next   = acc;
        load       = 1'b0;
        if (fire) begin
            if (eff_first) begin
                acc_next = ACCUM_WIDTH'(product);
            end else begin
                acc_next = ACCUM_WIDTH'(sat_add(fn_word_t'(acc), fn_word_t'(product),
                                                ACCUM_WIDTH, SATURATE));
            end
            load       = pe.data_last_in_L;
            state_next = pe.data_last_in_L ? ST_IDLE : ST_ACC;
        end
    end

    pe_result_stage #(
        .ACCUM_WIDTH (ACCUM_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH),
        .OUT_SHIFT   (OUT_SHIFT),
        .SATURATE    (SATURATE)
    ) u_result (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .load             (load),
        .acc_final        (acc_next),
        .drain_shift      (pe.drain_shift),
        .result_in        (pe.result_in_T),
        .result_valid_in  (pe.result_valid_in_T),
        .result_out       (pe.result_out_B),
        .result_valid_out (pe.result_valid_out_B),
        .err_overrun      (pe.err_overrun)
    );

    assign pe.data_out_R         = data_r;
    assign pe.data_valid_out_R   = data_valid_r;
    assign pe.data_first_out_R   = data_first_r;
    assign pe.data_last_out_R    = data_last_r;
    assign pe.weight_out_B       = weight_r;
    assign pe.weight_valid_out_B = weight_valid_r;
    assign pe.busy               = (state == ST_ACC);
    assign pe.err_mismatch       = err_mismatch_r;

endmodule

// File: tb/tb_systolic_pe_os.sv
module tb_systolic_pe_os;

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    // Shared stimulus for the three single-PE configurations.
    logic [15:0] s_d;
    logic [7:0]  s_w;
    logic        s_dv, s_wv, s_df, s_dl, s_ds;

    // Column stimulus.
    logic [15:0] c_d;
    logic [7:0]  c_w0, c_w1, c_w2;
    logic [2:0]  c_v;
    logic        c_fl, c_ds;

    systolic_pe_os_if if_a ();
    systolic_pe_os_if if_b ();
    systolic_pe_os_if if_c ();
    systolic_pe_os_if col0 ();
    systolic_pe_os_if col1 ();
    systolic_pe_os_if col2 ();

    assign if_a.data_in_L = s_d;  assign if_a.data_valid_in_L = s_dv;
    assign if_a.data_first_in_L = s_df;  assign if_a.data_last_in_L = s_dl;
    assign if_a.weight_in_T = s_w;  assign if_a.weight_valid_in_T = s_wv;
    assign if_a.drain_shift = s_ds;
    assign if_a.result_in_T = '0;  assign if_a.result_valid_in_T = 1'b0;

    assign if_b.data_in_L = s_d;  assign if_b.data_valid_in_L = s_dv;
    assign if_b.data_first_in_L = s_df;  assign if_b.data_last_in_L = s_dl;
    assign if_b.weight_in_T = s_w;  assign if_b.weight_valid_in_T = s_wv;
    assign if_b.drain_shift = s_ds;
    assign if_b.result_in_T = '0;  assign if_b.result_valid_in_T = 1'b0;

    assign if_c.data_in_L = s_d;  assign if_c.data_valid_in_L = s_dv;
    assign if_c.data_first_in_L = s_df;  assign if_c.data_last_in_L = s_dl;
    assign if_c.weight_in_T = s_w;  assign if_c.weight_valid_in_T = s_wv;
    assign if_c.drain_shift = s_ds;
    assign if_c.result_in_T = '0;  assign if_c.result_valid_in_T = 1'b0;

    assign col0.data_in_L = c_d;  assign col0.data_valid_in_L = c_v[0];
    assign col0.data_first_in_L = c_fl;  assign col0.data_last_in_L = c_fl;
    assign col0.weight_in_T = c_w0;  assign col0.weight_valid_in_T = c_v[0];
    assign col0.drain_shift = c_ds;
    assign col0.result_in_T = '0;  assign col0.result_valid_in_T = 1'b0;

    assign col1.data_in_L = c_d;  assign col1.data_valid_in_L = c_v[1];
    assign col1.data_first_in_L = c_fl;  assign col1.data_last_in_L = c_fl;
    assign col1.weight_in_T = c_w1;  assign col1.weight_valid_in_T = c_v[1];
    assign col1.drain_shift = c_ds;
    assign col1.result_in_T = col0.result_out_B;
    assign col1.result_valid_in_T = col0.result_valid_out_B;

    assign col2.data_in_L = c_d;  assign col2.data_valid_in_L = c_v[2];
    assign col2.data_first_in_L = c_fl;  assign col2.data_last_in_L = c_fl;
    assign col2.weight_in_T = c_w2;  assign col2.weight_valid_in_T = c_v[2];
    assign col2.drain_shift = c_ds;
    assign col2.result_in_T = col1.result_out_B;
    assign col2.result_valid_in_T = col1.result_valid_out_B;

    systolic_pe_os #(.OUT_SHIFT(0)) dut_a (.clk(clk), .rst(rst), .en(en), .pe(if_a));
    systolic_pe_os #(.OUT_SHIFT(6)) dut_b (.clk(clk), .rst(rst), .en(en), .pe(if_b));
    systolic_pe_os #(.OUT_SHIFT(0), .SATURATE(1'b0)) dut_c (.clk(clk), .rst(rst), .en(en), .pe(if_c));
    systolic_pe_os #(.OUT_SHIFT(0)) dut_col0 (.clk(clk), .rst(rst), .en(en), .pe(col0));
    systolic_pe_os #(.OUT_SHIFT(0)) dut_col1 (.clk(clk), .rst(rst), .en(en), .pe(col1));
    systolic_pe_os #(.OUT_SHIFT(0)) dut_col2 (.clk(clk), .rst(rst), .en(en), .pe(col2));

    typedef struct {
        int     n;
        int     d[8];
        int     w[8];
        longint exp_a;   // OUT_SHIFT=0, saturating
        longint exp_b;   // OUT_SHIFT=6, saturating
        longint exp_c;   // OUT_SHIFT=0, wrapping
    } vec_t;

    vec_t   vec[8];
    longint sb_a[$];
    longint sb_b[$];
    longint sb_c[$];
    longint sb_col[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference arithmetic on plain integers.
    function automatic longint fit(input longint x, input int w, input bit sat);
        longint lim, r;
        lim = longint'(1) << (w - 1);
        if (sat) begin
            if (x > lim - 1) return lim - 1;
            if (x < -lim) return -lim;
            return x;
        end
        r = x & ((lim << 1) - 1);
        if (r >= lim) r = r - (lim << 1);
        return r;
    endfunction

    function automatic longint round_ref(input longint acc, input int sh);
        longint den, num, q;
        den = longint'(1) << sh;
        num = acc + den / 2;
        q = num / den;
        if ((num % den) != 0 && num < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint model_acc(input vec_t v, input bit sat);
        longint a;
        a = 0;
        for (int k = 0; k < v.n; k++) a = fit(a + longint'(v.d[k]) * longint'(v.w[k]), 32, sat);
        return a;
    endfunction

    task automatic check_results();
        longint e;
        if (sb_a.size() == 0 || sb_b.size() == 0 || sb_c.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue, expected pending result");
        end else begin
            e = sb_a.pop_front();
            chk("result_a", $signed(if_a.result_out_B), e);
            chk("valid_a", if_a.result_valid_out_B, 1);
            e = sb_b.pop_front();
            chk("result_b", $signed(if_b.result_out_B), e);
            e = sb_c.pop_front();
            chk("result_c", $signed(if_c.result_out_B), e);
        end
    endtask

    task automatic idle_inputs();
        s_dv = 1'b0; s_wv = 1'b0; s_df = 1'b0; s_dl = 1'b0;
    endtask

    // Apply one tile; optionally stall (en=0) for three cycles after pair stall_after.
    task automatic run_tile(input vec_t v, input int stall_after);
        for (int k = 0; k < v.n; k++) begin
            s_d = 16'(v.d[k]); s_w = 8'(v.w[k]);
            s_dv = 1'b1; s_wv = 1'b1;
            s_df = (k == 0); s_dl = (k == v.n - 1);
            if (k == v.n - 1) begin
                sb_a.push_back(v.exp_a); sb_b.push_back(v.exp_b); sb_c.push_back(v.exp_c);
            end
            @(posedge clk); #1;
            chk("data_out_R", $signed(if_a.data_out_R), v.d[k]);
            chk("busy", if_a.busy, (k != v.n - 1));
            if (k == v.n - 1) check_results();
            if (k == stall_after) begin
                en = 1'b0; s_d = 16'h5a5a; s_wv = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("stall_data_out_R", $signed(if_a.data_out_R), v.d[k]);
                    chk("stall_busy", if_a.busy, 1);
                    chk("stall_err_mismatch", if_a.err_mismatch, 0);
                end
                en = 1'b1;
            end
        end
        idle_inputs();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, if_a.busy, 0);
        chk({tag, "_data_out_R"}, if_a.data_out_R, 0);
        chk({tag, "_data_valid_out_R"}, if_a.data_valid_out_R, 0);
        chk({tag, "_result_out_B"}, if_a.result_out_B, 0);
        chk({tag, "_result_valid_out_B"}, if_a.result_valid_out_B, 0);
        chk({tag, "_err_mismatch"}, if_a.err_mismatch, 0);
        chk({tag, "_err_overrun"}, if_a.err_overrun, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        longint acc_s, acc_w;

        vec[0].n = 3; vec[0].d = '{3, 4, 5, 0, 0, 0, 0, 0};          vec[0].w = '{2, -1, 5, 0, 0, 0, 0, 0};
        vec[1].n = 2; vec[1].d = '{48, 48, 0, 0, 0, 0, 0, 0};        vec[1].w = '{1, 1, 0, 0, 0, 0, 0, 0};
        vec[2].n = 2; vec[2].d = '{-48, -48, 0, 0, 0, 0, 0, 0};      vec[2].w = '{1, 1, 0, 0, 0, 0, 0, 0};
        vec[3].n = 8; vec[3].d = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
                      vec[3].w = '{127, 127, 127, 127, 127, 127, 127, 127};
        vec[4].n = 1; vec[4].d = '{-7, 0, 0, 0, 0, 0, 0, 0};         vec[4].w = '{3, 0, 0, 0, 0, 0, 0, 0};
        vec[5].n = 1; vec[5].d = '{-32768, 0, 0, 0, 0, 0, 0, 0};     vec[5].w = '{-128, 0, 0, 0, 0, 0, 0, 0};
        vec[6].n = 1; vec[6].d = '{2, 0, 0, 0, 0, 0, 0, 0};          vec[6].w = '{3, 0, 0, 0, 0, 0, 0, 0};
        vec[7].n = 1; vec[7].d = '{4, 0, 0, 0, 0, 0, 0, 0};          vec[7].w = '{4, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            acc_s = model_acc(vec[i], 1'b1);
            acc_w = model_acc(vec[i], 1'b0);
            vec[i].exp_a = fit(round_ref(acc_s, 0), 16, 1'b1);
            vec[i].exp_b = fit(round_ref(acc_s, 6), 16, 1'b1);
            vec[i].exp_c = fit(round_ref(acc_w, 0), 16, 1'b0);
        end

        rst = 1'b1; en = 1'b1;
        s_d = '0; s_w = '0; s_ds = 1'b1; idle_inputs();
        c_d = '0; c_w0 = '0; c_w1 = '0; c_w2 = '0; c_v = '0; c_fl = 1'b0; c_ds = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Table of tiles with the drain running continuously.
        for (int i = 0; i < 6; i++) begin
            run_tile(vec[i], -1);
            @(posedge clk); #1;
        end
        // Same first tile with a three-cycle stall after its first pair.
        run_tile(vec[0], 0);
        @(posedge clk); #1;
        chk("table_err_mismatch", if_a.err_mismatch, 0);
        chk("table_err_overrun", if_a.err_overrun, 0);

        // Column drain: loads 10,20,30, three shift pulses, new tile at top on the last pulse.
        c_d = 16'd10; c_w0 = 8'd1; c_w1 = 8'd2; c_w2 = 8'd3; c_v = 3'b111; c_fl = 1'b1;
        sb_col.push_back(30); sb_col.push_back(20); sb_col.push_back(10);
        @(posedge clk); #1;
        c_v = 3'b000;
        chk("col_bottom_0", $signed(col2.result_out_B), sb_col.pop_front());
        chk("col_bottom_valid_0", col2.result_valid_out_B, 1);
        for (int p = 0; p < 3; p++) begin
            c_ds = 1'b1;
            if (p == 2) begin
                c_w0 = 8'd5; c_v = 3'b001;
            end
            @(posedge clk); #1;
            c_ds = 1'b0; c_v = 3'b000;
            if (p < 2) begin
                if (sb_col.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL col_scoreboard: got empty queue, expected pending result");
                end else begin
                    chk("col_bottom", $signed(col2.result_out_B), sb_col.pop_front());
                end
                chk("col_bottom_valid", col2.result_valid_out_B, 1);
            end else begin
                chk("col_bottom_empty", col2.result_valid_out_B, 0);
                chk("col_top_reload", $signed(col0.result_out_B), 50);
                chk("col_top_reload_valid", col0.result_valid_out_B, 1);
            end
        end
        chk("col_overrun", {col0.err_overrun, col1.err_overrun, col2.err_overrun}, 0);

        // Overrun: second load while the first result is still held.
        s_ds = 1'b0;
        run_tile(vec[6], -1);
        chk("pre_overrun", if_a.err_overrun, 0);
        run_tile(vec[7], -1);
        chk("err_overrun", if_a.err_overrun, 1);

        // Mismatch: the lone-valid cycle must not disturb the sum.
        s_d = 16'd3; s_w = 8'd2; s_dv = 1'b1; s_wv = 1'b1; s_df = 1'b1; s_dl = 1'b0;
        @(posedge clk); #1;
        chk("mm_busy_first", if_a.busy, 1);
        s_d = 16'd100; s_wv = 1'b0; s_df = 1'b0;
        @(posedge clk); #1;
        chk("err_mismatch", if_a.err_mismatch, 1);
        chk("mm_busy_hold", if_a.busy, 1);
        s_d = 16'd1; s_w = 8'd1; s_wv = 1'b1; s_dl = 1'b1;
        sb_a.push_back(longint'(3 * 2 + 1 * 1));
        @(posedge clk); #1;
        idle_inputs();
        chk("mm_result", $signed(if_a.result_out_B), sb_a.pop_front());
        chk("mm_busy_done", if_a.busy, 0);

        // Reset in the middle of a tile.
        s_d = 16'd9; s_w = 8'd9; s_dv = 1'b1; s_wv = 1'b1; s_df = 1'b1; s_dl = 1'b0;
        @(posedge clk); #1;
        idle_inputs();
        chk("pre_reset_busy", if_a.busy, 1);
        rst = 1'b1;
        #1;
        check_reset_state("midreset");
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
